regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port integer register file with a per-register busy scoreboard.
//  Serves the issue and writeback stages of a multi-issue RISC-V pipeline.
//  Reads are synchronous, with optional same-cycle write->read bypass.
//  x0 is hardwired to zero and is never busy.
// PARAMETERS
//  WIDTH   32  data width of each architectural register
//  NUM_RD  2   number of read ports (>=1)
//  NUM_WR  1   number of write ports (>=1)
//  BYPASS  1   1: read returns same-edge write data; 0: read returns pre-edge contents
// PORTS
//  clk       in   1             single clock; all state updates on posedge
//  rst       in   1             synchronous, active-high reset
//  rd_en     in   NUM_RD        per-port read enable
//  rd_addr   in   NUM_RD*5      read register index; port i = [5i+4:5i]
//  rd_data   out  NUM_RD*WIDTH  registered read data; port i = [WIDTH*i +: WIDTH]
//  rd_busy   out  NUM_RD        registered busy flag of the register read on port i
//  wr_en     in   NUM_WR        per-port write enable
//  wr_addr   in   NUM_WR*5      write register index
//  wr_data   in   NUM_WR*WIDTH  write data
//  iss_en    in   1             issue: mark iss_rd busy (a producer is in flight)
//  iss_rd    in   5             destination register being issued
//  flush     in   1             clear every busy bit (pipeline squash)
// BEHAVIOUR
//  Reset (rst=1 at posedge): all 32 registers, all busy bits, rd_data and rd_busy go to 0.
//  Reset overrides every other input in that cycle.
//  Write: at posedge, if wr_en[j] && wr_addr[j]!=0, then reg[wr_addr[j]] <= wr_data[j].
//   - Writes with wr_addr=0 are discarded.
//   - If several ports target the same address in one cycle, the highest j wins.
//  Read: latency 1.
//   - At posedge, if rd_en[i], rd_data[i] <= value of reg[rd_addr[i]].
//   - rd_addr=0 always returns 0.
//   - BYPASS=1 with a same-edge write to that address: returns wr_data of the winning port.
//   - BYPASS=0: returns the contents before the edge.
//   - If rd_en[i]=0, both rd_data[i] and rd_busy[i] hold their previous values.
//  Scoreboard:
//   - busy_nxt = flush ? 0 : ((busy & ~clr) | set).
//   - clr[r] = any wr_en[j] with wr_addr[j]==r.
//   - set[r] = iss_en && iss_rd==r && r!=0.
//   - Set and clear on the same register in the same cycle: set wins (a new producer).
//   - flush wins over iss_en (the issue is squashed).
//   - busy[0] is constantly 0.
//  rd_busy[i] <= busy_nxt[rd_addr[i]] when rd_en[i].
//   - This is consistent with rd_data: a read that bypasses a writeback returns busy=0
//     unless the same cycle also issues that register.
//  No handshake back-pressure: every enable is accepted in the cycle it is asserted.
//  Out-of-range parameters (NUM_RD=0, NUM_WR=0) are not supported; an elaboration-time check flags them.
// STRUCTURE
//  regfile_pkg holds:
//   - REG_ADDR_W=5, NUM_ARCH_REGS=32, REG_ZERO=5'd0
//   - the function wr_winner(), which returns the highest matching write port, shared with bypass logic.
//  Sub-module regfile_scoreboard holds:
//   - the 32-bit busy vector and its set/clear/flush logic
//   - it exports busy_nxt.
//  Top level holds:
//   - the register array
//   - the write priority mux
//   - per-read-port bypass, generated over NUM_RD.
// TESTING
//  1. Reset:
//     - write all regs, then rst=1 for 1 cycle
//     - read x1..x31 -> all 0, rd_busy=0.
//  2. Basic write and read:
//     - write x5=0xDEADBEEF
//     - next cycle read x5 on port 0 -> rd_data=0xDEADBEEF one cycle later.
//  3. x0:
//     - write x0=0x1234, iss_en with iss_rd=0
//     - read x0 -> data 0, busy 0.
//  4. Bypass (NUM_WR=2):
//     - same edge: wr0 x7=0x11, wr1 x7=0x22, read x7
//     - BYPASS=1 -> 0x22
//     - BYPASS=0 -> old value; the following read returns 0x22.
//  5. Scoreboard:
//     - iss x9 -> read busy=1
//     - wb x9 plus iss x9 in the same cycle -> busy=1
//     - wb only -> busy=0
//     - iss x9 plus flush -> busy=0.
//  6. Read hold:
//     - rd_en=0 while x3 is rewritten -> rd_data keeps its old value until rd_en=1.
//  7. Random check: 10k cycles of random traffic compared against a reference model, including rst mid-stream.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port integer register file.
// Included by the interface, the scoreboard and the top level.
package regfile_pkg;

   localparam int REG_ADDR_W    = 5;
   localparam int NUM_ARCH_REGS = 32;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   // Upper bound on write ports so wr_winner() can take fixed-width vectors.
   localparam int MAX_WR = 8;

   // Returns the highest write port whose enable is set and whose address matches target, or -1.
   function automatic int wr_winner(input logic [MAX_WR-1:0]            en,
                                    input logic [MAX_WR*REG_ADDR_W-1:0] addr,
                                    input logic [REG_ADDR_W-1:0]        target);
      int win;
      win = -1;
      for (int j = 0; j < MAX_WR; j++) begin
         if (en[j] && (addr[j*REG_ADDR_W +: REG_ADDR_W] == target)) win = j;
      end
      return win;
   endfunction

endpackage

// File: rtl/regfile_if.sv
// Issue/writeback/read bundle of the register file.
// The pipeline side is the master; the register file is the slave.
interface regfile_if
   import regfile_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 1
);
   logic [NUM_RD-1:0]            rd_en;
   logic [NUM_RD*REG_ADDR_W-1:0] rd_addr;
   logic [NUM_RD*WIDTH-1:0]      rd_data;
   logic [NUM_RD-1:0]            rd_busy;
   logic [NUM_WR-1:0]            wr_en;
   logic [NUM_WR*REG_ADDR_W-1:0] wr_addr;
   logic [NUM_WR*WIDTH-1:0]      wr_data;
   logic                         iss_en;
   logic [REG_ADDR_W-1:0]        iss_rd;
   logic                         flush;

   modport master (
      output rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd, flush,
      input  rd_data, rd_busy
   );

   modport slave (
      input  rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd, flush,
      output rd_data, rd_busy
   );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set on issue, cleared on writeback, wiped by flush.
// Exports the next-state vector so read ports can report it in the same cycle.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NUM_WR = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_WR-1:0]            i_wr_en,
   input  logic [NUM_WR*REG_ADDR_W-1:0] i_wr_addr,
   input  logic                         i_iss_en,
   input  logic [REG_ADDR_W-1:0]        i_iss_rd,
   input  logic                         i_flush,
   output logic [NUM_ARCH_REGS-1:0]     o_busy_nxt
);

   logic [NUM_ARCH_REGS-1:0] r_busy;
   logic [NUM_ARCH_REGS-1:0] w_clr;
   logic [NUM_ARCH_REGS-1:0] w_set;
   logic [NUM_ARCH_REGS-1:0] w_busy_nxt;

   // Set is applied after clear so a re-issue in the writeback cycle keeps the register busy.
   always_comb begin
      w_clr = '0;
      w_set = '0;
      for (int j = 0; j < NUM_WR; j++) begin
         if (i_wr_en[j]) w_clr[i_wr_addr[j*REG_ADDR_W +: REG_ADDR_W]] = 1'b1;
      end
      if (i_iss_en && (i_iss_rd != REG_ZERO)) w_set[i_iss_rd] = 1'b1;
      w_busy_nxt = i_flush ? '0 : ((r_busy & ~w_clr) | w_set);
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) r_busy <= '0;
      else     r_busy <= w_busy_nxt;
   end

   assign o_busy_nxt = w_busy_nxt;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with synchronous reads, optional write->read
// bypass, hardwired x0 and a busy scoreboard for in-flight producers.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 1,
   parameter int BYPASS = 1
) (
   input logic      clk,
   input logic      rst,
   regfile_if.slave bus
);

   if (NUM_RD < 1 || NUM_WR < 1 || NUM_WR > MAX_WR) begin : g_param_check
      $error("regfile_mp: NUM_RD and NUM_WR must be >= 1 and NUM_WR <= MAX_WR");
   end

   logic [WIDTH-1:0]               r_regs [NUM_ARCH_REGS];
   logic [MAX_WR-1:0]              w_wr_en_ext;
   logic [MAX_WR*REG_ADDR_W-1:0]   w_wr_addr_ext;
   logic                           w_wr_hit [NUM_ARCH_REGS];
   logic [WIDTH-1:0]               w_wr_val [NUM_ARCH_REGS];
   logic [NUM_ARCH_REGS-1:0]       w_busy_nxt;
   logic [WIDTH-1:0]               w_rd_val [NUM_RD];
   logic                           w_rd_bsy [NUM_RD];
   logic [WIDTH-1:0]               r_rd_data [NUM_RD];
   logic [NUM_RD-1:0]              r_rd_busy;
   logic [NUM_RD*WIDTH-1:0]        w_rd_data_flat;

   always_comb begin
      w_wr_en_ext   = '0;
      w_wr_addr_ext = '0;
      w_wr_en_ext[NUM_WR-1:0]              = bus.wr_en;
      w_wr_addr_ext[NUM_WR*REG_ADDR_W-1:0] = bus.wr_addr;
   end

   // One priority mux per architectural register; the read bypass reuses the same result.
   always_comb begin
      int win;
      for (int r = 0; r < NUM_ARCH_REGS; r++) begin
         win         = wr_winner(w_wr_en_ext, w_wr_addr_ext, REG_ADDR_W'(r));
         w_wr_hit[r] = (win >= 0) && (r != 0);
         w_wr_val[r] = '0;
         if (win >= 0) w_wr_val[r] = bus.wr_data[win*WIDTH +: WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NUM_ARCH_REGS; r++) r_regs[r] <= '0;
      end else begin
         for (int r = 1; r < NUM_ARCH_REGS; r++) begin
            if (w_wr_hit[r]) r_regs[r] <= w_wr_val[r];
         end
      end
   end

   regfile_scoreboard #(
      .NUM_WR (NUM_WR)
   ) u_scoreboard (
      .clk        (clk),
      .rst        (rst),
      .i_wr_en    (bus.wr_en),
      .i_wr_addr  (bus.wr_addr),
      .i_iss_en   (bus.iss_en),
      .i_iss_rd   (bus.iss_rd),
      .i_flush    (bus.flush),
      .o_busy_nxt (w_busy_nxt)
   );

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [REG_ADDR_W-1:0] w_addr;
      logic                  w_byp;

      assign w_addr      = bus.rd_addr[i*REG_ADDR_W +: REG_ADDR_W];
      assign w_byp       = (BYPASS != 0) && w_wr_hit[w_addr];
      assign w_rd_val[i] = (w_addr == REG_ZERO) ? '0 :
                           w_byp                ? w_wr_val[w_addr] : r_regs[w_addr];
      assign w_rd_bsy[i] = w_busy_nxt[w_addr];
   end

   // Disabled read ports hold both data and busy.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_RD; i++) r_rd_data[i] <= '0;
         r_rd_busy <= '0;
      end else begin
         for (int i = 0; i < NUM_RD; i++) begin
            if (bus.rd_en[i]) begin
               r_rd_data[i] <= w_rd_val[i];
               r_rd_busy[i] <= w_rd_bsy[i];
            end
         end
      end
   end

   always_comb begin
      w_rd_data_flat = '0;
      for (int i = 0; i < NUM_RD; i++) w_rd_data_flat[i*WIDTH +: WIDTH] = r_rd_data[i];
   end

   assign bus.rd_data = w_rd_data_flat;
   assign bus.rd_busy = r_rd_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed and randomised bench for regfile_mp; drives a BYPASS=1 and a BYPASS=0
// instance with identical stimulus and checks both.
module tb_regfile_mp;
   import regfile_pkg::*;

   localparam int W  = 32;
   localparam int NR = 2;
   localparam int NW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [NR-1:0]   rd_en;
   logic [NR*5-1:0] rd_addr;
   logic [NW-1:0]   wr_en;
   logic [NW*5-1:0] wr_addr;
   logic [NW*W-1:0] wr_data;
   logic            iss_en;
   logic [4:0]      iss_rd;
   logic            flush;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] m_regs [32];
   logic [31:0] m_busy;
   logic [31:0] e1 [NR];
   logic [31:0] e0 [NR];
   logic        eb [NR];

   regfile_if #(.WIDTH(W), .NUM_RD(NR), .NUM_WR(NW)) bus1 ();
   regfile_if #(.WIDTH(W), .NUM_RD(NR), .NUM_WR(NW)) bus0 ();

   assign bus1.rd_en   = rd_en;
   assign bus1.rd_addr = rd_addr;
   assign bus1.wr_en   = wr_en;
   assign bus1.wr_addr = wr_addr;
   assign bus1.wr_data = wr_data;
   assign bus1.iss_en  = iss_en;
   assign bus1.iss_rd  = iss_rd;
   assign bus1.flush   = flush;
   assign bus0.rd_en   = rd_en;
   assign bus0.rd_addr = rd_addr;
   assign bus0.wr_en   = wr_en;
   assign bus0.wr_addr = wr_addr;
   assign bus0.wr_data = wr_data;
   assign bus0.iss_en  = iss_en;
   assign bus0.iss_rd  = iss_rd;
   assign bus0.flush   = flush;

   regfile_mp #(.WIDTH(W), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1)) dut_b1 (
      .clk (clk), .rst (rst), .bus (bus1)
   );
   regfile_mp #(.WIDTH(W), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(0)) dut_b0 (
      .clk (clk), .rst (rst), .bus (bus0)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rd_en   = '0;
      rd_addr = '0;
      wr_en   = '0;
      wr_addr = '0;
      wr_data = '0;
      iss_en  = 1'b0;
      iss_rd  = '0;
      flush   = 1'b0;
   endtask

   task automatic set_rd(input int p, input logic [4:0] a);
      rd_en[p]         = 1'b1;
      rd_addr[p*5 +: 5] = a;
   endtask

   task automatic set_wr(input int p, input logic [4:0] a, input logic [31:0] d);
      wr_en[p]          = 1'b1;
      wr_addr[p*5 +: 5] = a;
      wr_data[p*W +: W] = d;
   endtask

   function automatic logic [4:0] pick();
      if ($urandom_range(0, 3) == 0) return 5'($urandom);
      return 5'($urandom_range(0, 7));
   endfunction

   task automatic test_reset();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_tests++;
      if ({bus1.rd_data, bus0.rd_data} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got %h/%h exp 0", bus1.rd_data, bus0.rd_data);
      end
      n_tests++;
      if ({bus1.rd_busy, bus0.rd_busy} !== '0) begin
         n_fail++;
         $display("FAIL reset_busy: got %b/%b exp 0", bus1.rd_busy, bus0.rd_busy);
      end
      for (int r = 1; r < 32; r++) begin
         idle();
         set_wr(0, 5'(r), 32'hA500_0000 | r);
         iss_en = 1'b1;
         iss_rd = 5'(r);
         tick();
      end
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int r = 1; r < 32; r++) begin
         idle();
         set_rd(0, 5'(r));
         set_rd(1, 5'(32 - r));
         tick();
         n_tests++;
         if ({bus1.rd_data, bus0.rd_data, bus1.rd_busy, bus0.rd_busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_x%0d: got d1=%h d0=%h b1=%b b0=%b exp all 0",
                     r, bus1.rd_data, bus0.rd_data, bus1.rd_busy, bus0.rd_busy);
         end
      end
   endtask

   task automatic test_basic_rw();
      idle();
      set_wr(0, 5'd5, 32'hDEADBEEF);
      tick();
      idle();
      set_rd(0, 5'd5);
      set_rd(1, 5'd5);
      tick();
      n_tests++;
      if (bus1.rd_data !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
         n_fail++;
         $display("FAIL basic_b1: got %h exp DEADBEEF on both ports", bus1.rd_data);
      end
      n_tests++;
      if (bus0.rd_data !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
         n_fail++;
         $display("FAIL basic_b0: got %h exp DEADBEEF on both ports", bus0.rd_data);
      end
      n_tests++;
      if ({bus1.rd_busy, bus0.rd_busy} !== 4'b0000) begin
         n_fail++;
         $display("FAIL basic_busy: got %b/%b exp 0", bus1.rd_busy, bus0.rd_busy);
      end
   endtask

   task automatic test_x0();
      idle();
      set_wr(0, 5'd0, 32'h1234);
      iss_en = 1'b1;
      iss_rd = 5'd0;
      set_rd(0, 5'd0);
      tick();
      n_tests++;
      if (bus1.rd_data[31:0] !== 32'h0 || bus0.rd_data[31:0] !== 32'h0) begin
         n_fail++;
         $display("FAIL x0_data: got %h/%h exp 0", bus1.rd_data[31:0], bus0.rd_data[31:0]);
      end
      n_tests++;
      if (bus1.rd_busy[0] !== 1'b0 || bus0.rd_busy[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL x0_busy: got %b/%b exp 0", bus1.rd_busy[0], bus0.rd_busy[0]);
      end
      idle();
      set_rd(0, 5'd0);
      set_rd(1, 5'd0);
      tick();
      n_tests++;
      if ({bus1.rd_data, bus0.rd_data, bus1.rd_busy, bus0.rd_busy} !== '0) begin
         n_fail++;
         $display("FAIL x0_reread: got d1=%h d0=%h b1=%b b0=%b exp all 0",
                  bus1.rd_data, bus0.rd_data, bus1.rd_busy, bus0.rd_busy);
      end
   endtask

   task automatic test_bypass();
      idle();
      set_wr(0, 5'd7, 32'h55);
      tick();
      idle();
      set_wr(0, 5'd7, 32'h11);
      set_wr(1, 5'd7, 32'h22);
      set_rd(0, 5'd7);
      tick();
      n_tests++;
      if (bus1.rd_data[31:0] !== 32'h22) begin
         n_fail++;
         $display("FAIL bypass_b1: got %h exp 00000022", bus1.rd_data[31:0]);
      end
      n_tests++;
      if (bus0.rd_data[31:0] !== 32'h55) begin
         n_fail++;
         $display("FAIL bypass_b0_old: got %h exp 00000055", bus0.rd_data[31:0]);
      end
      idle();
      set_rd(0, 5'd7);
      tick();
      n_tests++;
      if (bus1.rd_data[31:0] !== 32'h22 || bus0.rd_data[31:0] !== 32'h22) begin
         n_fail++;
         $display("FAIL bypass_after: got %h/%h exp 00000022", bus1.rd_data[31:0], bus0.rd_data[31:0]);
      end
      idle();
      set_wr(0, 5'd8, 32'h81);
      set_rd(1, 5'd8);
      tick();
      n_tests++;
      if (bus1.rd_data[63:32] !== 32'h81 || bus0.rd_data[63:32] !== 32'h0) begin
         n_fail++;
         $display("FAIL bypass_port1: got %h/%h exp 00000081/00000000",
                  bus1.rd_data[63:32], bus0.rd_data[63:32]);
      end
   endtask

   task automatic test_scoreboard();
      idle();
      iss_en = 1'b1; iss_rd = 5'd9; set_rd(0, 5'd9);
      tick();
      n_tests++;
      if (bus1.rd_busy[0] !== 1'b1 || bus0.rd_busy[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL sb_issue: got %b/%b exp 1", bus1.rd_busy[0], bus0.rd_busy[0]);
      end
      idle();
      set_rd(0, 5'd9);
      tick();
      n_tests++;
      if (bus1.rd_busy[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL sb_hold_busy: got %b exp 1", bus1.rd_busy[0]);
      end
      idle();
      set_wr(0, 5'd9, 32'h99); iss_en = 1'b1; iss_rd = 5'd9; set_rd(0, 5'd9);
      tick();
      n_tests++;
      if (bus1.rd_busy[0] !== 1'b1 || bus0.rd_busy[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL sb_wb_and_iss: got %b/%b exp 1", bus1.rd_busy[0], bus0.rd_busy[0]);
      end
      n_tests++;
      if (bus1.rd_data[31:0] !== 32'h99 || bus0.rd_data[31:0] !== 32'h0) begin
         n_fail++;
         $display("FAIL sb_wb_data: got %h/%h exp 00000099/00000000", bus1.rd_data[31:0], bus0.rd_data[31:0]);
      end
      idle();
      set_wr(0, 5'd9, 32'hAA); set_rd(0, 5'd9);
      tick();
      n_tests++;
      if (bus1.rd_busy[0] !== 1'b0 || bus0.rd_busy[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL sb_wb_only: got %b/%b exp 0", bus1.rd_busy[0], bus0.rd_busy[0]);
      end
      n_tests++;
      if (bus1.rd_data[31:0] !== 32'hAA || bus0.rd_data[31:0] !== 32'h99) begin
         n_fail++;
         $display("FAIL sb_wb_only_data: got %h/%h exp 000000AA/00000099", bus1.rd_data[31:0], bus0.rd_data[31:0]);
      end
      idle();
      iss_en = 1'b1; iss_rd = 5'd9; flush = 1'b1; set_rd(0, 5'd9);
      tick();
      n_tests++;
      if (bus1.rd_busy[0] !== 1'b0 || bus0.rd_busy[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL sb_flush_wins: got %b/%b exp 0", bus1.rd_busy[0], bus0.rd_busy[0]);
      end
      idle();
      set_rd(0, 5'd9);
      tick();
      n_tests++;
      if (bus1.rd_busy[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL sb_after_flush: got %b exp 0", bus1.rd_busy[0]);
      end
      idle();
      iss_en = 1'b1; iss_rd = 5'd9;
      tick();
      idle();
      set_wr(1, 5'd9, 32'hBB); set_rd(1, 5'd9);
      tick();
      n_tests++;
      if (bus1.rd_busy[1] !== 1'b0 || bus1.rd_data[63:32] !== 32'hBB) begin
         n_fail++;
         $display("FAIL sb_wb_port1: got busy %b data %h exp 0/000000BB", bus1.rd_busy[1], bus1.rd_data[63:32]);
      end
      idle();
      iss_en = 1'b1; iss_rd = 5'd9;
      tick();
      idle();
      flush = 1'b1; set_rd(0, 5'd9);
      tick();
      n_tests++;
      if (bus1.rd_busy[0] !== 1'b0 || bus0.rd_busy[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL sb_flush_only: got %b/%b exp 0", bus1.rd_busy[0], bus0.rd_busy[0]);
      end
   endtask

   task automatic test_read_hold();
      idle();
      set_wr(0, 5'd3, 32'h333);
      tick();
      idle();
      set_rd(0, 5'd3);
      tick();
      n_tests++;
      if (bus1.rd_data[31:0] !== 32'h333 || bus0.rd_data[31:0] !== 32'h333) begin
         n_fail++;
         $display("FAIL hold_first: got %h/%h exp 00000333", bus1.rd_data[31:0], bus0.rd_data[31:0]);
      end
      idle();
      set_wr(0, 5'd3, 32'h444); iss_en = 1'b1; iss_rd = 5'd3;
      tick();
      n_tests++;
      if (bus1.rd_data[31:0] !== 32'h333 || bus0.rd_data[31:0] !== 32'h333 ||
          bus1.rd_busy[0] !== 1'b0 || bus0.rd_busy[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_disabled: got %h/%h busy %b/%b exp 00000333 busy 0",
                  bus1.rd_data[31:0], bus0.rd_data[31:0], bus1.rd_busy[0], bus0.rd_busy[0]);
      end
      idle();
      tick();
      n_tests++;
      if (bus1.rd_data[31:0] !== 32'h333 || bus0.rd_data[31:0] !== 32'h333) begin
         n_fail++;
         $display("FAIL hold_idle: got %h/%h exp 00000333", bus1.rd_data[31:0], bus0.rd_data[31:0]);
      end
      idle();
      set_rd(0, 5'd3);
      tick();
      n_tests++;
      if (bus1.rd_data[31:0] !== 32'h444 || bus0.rd_data[31:0] !== 32'h444 ||
          bus1.rd_busy[0] !== 1'b1 || bus0.rd_busy[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL hold_reenable: got %h/%h busy %b/%b exp 00000444 busy 1",
                  bus1.rd_data[31:0], bus0.rd_data[31:0], bus1.rd_busy[0], bus0.rd_busy[0]);
      end
      idle();
      flush = 1'b1;
      tick();
      idle();
   endtask

   task automatic test_random();
      logic [31:0] nb;
      logic [4:0]  a;
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int r = 0; r < 32; r++) m_regs[r] = '0;
      m_busy = '0;
      for (int p = 0; p < NR; p++) begin
         e1[p] = '0; e0[p] = '0; eb[p] = 1'b0;
      end
      for (int c = 0; c < 10000; c++) begin
         rst    = ($urandom_range(0, 399) == 0);
         rd_en  = NR'($urandom);
         wr_en  = NW'($urandom);
         for (int p = 0; p < NR; p++) rd_addr[p*5 +: 5] = pick();
         for (int j = 0; j < NW; j++) begin
            wr_addr[j*5 +: 5] = pick();
            wr_data[j*W +: W] = $urandom;
         end
         iss_en = ($urandom_range(0, 2) == 0);
         iss_rd = pick();
         flush  = ($urandom_range(0, 24) == 0);
         if (rst) begin
            nb = '0;
            for (int r = 0; r < 32; r++) m_regs[r] = '0;
            for (int p = 0; p < NR; p++) begin
               e1[p] = '0; e0[p] = '0; eb[p] = 1'b0;
            end
         end else begin
            nb = m_busy;
            for (int j = 0; j < NW; j++) if (wr_en[j]) nb[wr_addr[j*5 +: 5]] = 1'b0;
            if (iss_en && iss_rd != 5'd0) nb[iss_rd] = 1'b1;
            if (flush) nb = '0;
            nb[0] = 1'b0;
            for (int p = 0; p < NR; p++) begin
               if (rd_en[p]) begin
                  a = rd_addr[p*5 +: 5];
                  e0[p] = (a == 5'd0) ? 32'h0 : m_regs[a];
                  e1[p] = e0[p];
                  for (int j = 0; j < NW; j++) begin
                     if (a != 5'd0 && wr_en[j] && wr_addr[j*5 +: 5] == a) e1[p] = wr_data[j*W +: W];
                  end
                  eb[p] = nb[a];
               end
            end
            for (int j = 0; j < NW; j++) begin
               if (wr_en[j] && wr_addr[j*5 +: 5] != 5'd0) m_regs[wr_addr[j*5 +: 5]] = wr_data[j*W +: W];
            end
         end
         m_busy = nb;
         tick();
         for (int p = 0; p < NR; p++) begin
            n_tests++;
            if (bus1.rd_data[p*W +: W] !== e1[p] || bus0.rd_data[p*W +: W] !== e0[p] ||
                bus1.rd_busy[p] !== eb[p] || bus0.rd_busy[p] !== eb[p]) begin
               n_fail++;
               $display("FAIL random c%0d p%0d: got d1=%h d0=%h b1=%b b0=%b exp d1=%h d0=%h b=%b",
                        c, p, bus1.rd_data[p*W +: W], bus0.rd_data[p*W +: W],
                        bus1.rd_busy[p], bus0.rd_busy[p], e1[p], e0[p], eb[p]);
            end
         end
      end
      rst = 1'b0;
      idle();
   endtask

   initial begin
      idle();
      rst = 1'b1;
      test_reset();
      test_basic_rw();
      test_x0();
      test_bypass();
      test_scoreboard();
      test_read_hold();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
